fp_argmax_seq: RTL and testbench

- Streaming reducer one stage downstream of the floating-point less-than comparator `comp`.
- Consumes a burst of IEEE-754 single-precision values on a valid/ready stream and feeds each value, with the running maximum, into `comp`.
- Uses the comparator flag to track the running maximum and the index of its first occurrence.
- After the beat marked last, presents {max, index, count, overflow} on a valid/ready result port; used for classifier argmax and peak detection.

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_argmax_seq_comp.sv | 29 ++
 rtl/fp_argmax_seq.sv | 157 +++++++++++++++
 tb/tb_fp_argmax_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision definitions: field positions, canonical quiet NaN,
// the argmax reducer's state encoding and a NaN classifier.
package fp_pkg;

    localparam int FP_W    = 32;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_W   = 23;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic is_nan(input logic [FP_W-1:0] v);
        return (v[EXP_MSB:EXP_LSB] == 8'hFF) && (v[MAN_W-1:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_argmax_seq_comp.sv
// Combinational IEEE-754 single-precision less-than comparator (a < b).
// NaN operands raise exception and report lt=0; +0 and -0 compare equal.
module comp
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            lt,
    output logic            exception
);

    // Sign-magnitude ordering with the zero and NaN special cases
    always_comb begin
        lt        = 1'b0;
        exception = is_nan(a) | is_nan(b);
        if (exception) begin
            lt = 1'b0;
        end else if ((a[FP_W-2:0] == 31'd0) && (b[FP_W-2:0] == 31'd0)) begin
            lt = 1'b0;
        end else if (a[FP_W-1] != b[FP_W-1]) begin
            lt = a[FP_W-1];
        end else if (!a[FP_W-1]) begin
            lt = (a[FP_W-2:0] < b[FP_W-2:0]);
        end else begin
            lt = (a[FP_W-2:0] > b[FP_W-2:0]);
        end
    end

endmodule

// File: rtl/fp_argmax_seq.sv
// Streaming argmax over a burst of single-precision values: running maximum,
// first index, element count and overflow. NaN filtering: FP_ARGMAX_NAN_FILTER_EN.
module fp_argmax_seq
    import fp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_index,
    output logic [IDX_W:0]    out_count,
    output logic              out_overflow
);

    localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};

    state_t              state_r;
    logic [DATA_W-1:0]   cur_max_r;
    logic [IDX_W-1:0]    cur_idx_r;
    logic [IDX_W:0]      elem_cnt_r;
    logic                ovf_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_max_r;
    logic [IDX_W-1:0]    out_index_r;
    logic [IDX_W:0]      out_count_r;
    logic                out_overflow_r;
`ifdef FP_ARGMAX_NAN_FILTER_EN
    logic                seeded_r;
`endif

    logic                accept_s;
    logic                lt_s;
    logic                cmp_exc_s;
    logic                take_s;
    logic [IDX_W-1:0]    cur_pos_s;
    logic [IDX_W:0]      cnt_next_s;
    logic                ovf_next_s;
    logic [DATA_W-1:0]   max_next_s;
    logic [IDX_W-1:0]    idx_next_s;
    logic [DATA_W-1:0]   res_max_s;
    logic [IDX_W-1:0]    res_idx_s;

    comp u_comp (
        .a         (cur_max_r),
        .b         (in_data),
        .lt        (lt_s),
        .exception (cmp_exc_s)
    );

    // Next running max/index/count for the element offered this cycle
    always_comb begin
        accept_s   = in_valid & in_ready_r;
        cur_pos_s  = elem_cnt_r[IDX_W] ? {IDX_W{1'b1}} : elem_cnt_r[IDX_W-1:0];
        cnt_next_s = elem_cnt_r[IDX_W] ? elem_cnt_r
                                       : elem_cnt_r + {{IDX_W{1'b0}}, 1'b1};
        ovf_next_s = ovf_r | (~in_last & (cnt_next_s == CNT_MAX));
`ifdef FP_ARGMAX_NAN_FILTER_EN
        // NaNs never seed or replace; an unseeded burst reports quiet NaN
        take_s     = ~is_nan(in_data) & (~seeded_r | lt_s);
        max_next_s = take_s ? in_data : cur_max_r;
        idx_next_s = take_s ? cur_pos_s : cur_idx_r;
        res_max_s  = (seeded_r | take_s) ? max_next_s : QNAN;
        res_idx_s  = (seeded_r | take_s) ? idx_next_s : {IDX_W{1'b0}};
`else
        take_s     = (state_r == ST_IDLE) | lt_s;
        max_next_s = take_s ? in_data : cur_max_r;
        idx_next_s = take_s ? cur_pos_s : cur_idx_r;
        res_max_s  = max_next_s;
        res_idx_s  = idx_next_s;
`endif
    end

    // Control FSM, running state and registered result port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cur_max_r      <= {DATA_W{1'b0}};
            cur_idx_r      <= {IDX_W{1'b0}};
            elem_cnt_r     <= {(IDX_W+1){1'b0}};
            ovf_r          <= 1'b0;
            in_ready_r     <= 1'b1;
            out_valid_r    <= 1'b0;
            out_max_r      <= {DATA_W{1'b0}};
            out_index_r    <= {IDX_W{1'b0}};
            out_count_r    <= {(IDX_W+1){1'b0}};
            out_overflow_r <= 1'b0;
`ifdef FP_ARGMAX_NAN_FILTER_EN
            seeded_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_SCAN: begin
                    if (accept_s) begin
                        cur_max_r  <= max_next_s;
                        cur_idx_r  <= idx_next_s;
                        elem_cnt_r <= cnt_next_s;
                        ovf_r      <= ovf_next_s;
`ifdef FP_ARGMAX_NAN_FILTER_EN
                        seeded_r   <= seeded_r | take_s;
`endif
                        if (in_last) begin
                            state_r        <= ST_HOLD;
                            in_ready_r     <= 1'b0;
                            out_valid_r    <= 1'b1;
                            out_max_r      <= res_max_s;
                            out_index_r    <= res_idx_s;
                            out_count_r    <= cnt_next_s;
                            out_overflow_r <= ovf_next_s;
                        end else begin
                            state_r <= ST_SCAN;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        cur_max_r   <= {DATA_W{1'b0}};
                        cur_idx_r   <= {IDX_W{1'b0}};
                        elem_cnt_r  <= {(IDX_W+1){1'b0}};
                        ovf_r       <= 1'b0;
`ifdef FP_ARGMAX_NAN_FILTER_EN
                        seeded_r    <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_max      = out_max_r;
    assign out_index    = out_index_r;
    assign out_count    = out_count_r;
    assign out_overflow = out_overflow_r;

endmodule

// File: tb/tb_fp_argmax_seq.sv
// Directed bench for fp_argmax_seq: expected results are queued as each burst
// is driven and compared when the result handshake occurs.
module tb_fp_argmax_seq;

    typedef struct packed {
        logic [31:0] mx;
        logic [3:0]  idx;
        logic [4:0]  cnt;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_max;
    logic [3:0]  out_index;
    logic [4:0]  out_count;
    logic        out_overflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    fp_argmax_seq #(.DATA_W(32), .IDX_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_max      (out_max),
        .out_index    (out_index),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at a sampling point; waits (bounded) for out_valid, then compares
    task automatic get_result(input string tag, input bit immediate);
        int   w = 0;
        res_t e;
        while (out_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (immediate) check({tag, "_latency"}, 64'(w), 64'd0);
        check({tag, "_sb_has_entry"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_max"},   64'(out_max),      64'(e.mx));
            check({tag, "_index"}, 64'(out_index),    64'(e.idx));
            check({tag, "_count"}, 64'(out_count),    64'(e.cnt));
            check({tag, "_ovf"},   64'(out_overflow), 64'(e.ovf));
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_one_cycle"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),     64'd1);
        check("rst_out_valid", 64'(out_valid),    64'd0);
        check("rst_out_max",   64'(out_max),      64'd0);
        check("rst_out_index", 64'(out_index),    64'd0);
        check("rst_out_count", 64'(out_count),    64'd0);
        check("rst_out_ovf",   64'(out_overflow), 64'd0);
        @(posedge clk);
        #1;

        // Mixed-sign burst, max in the middle
        sb.push_back('{mx: 32'h4000_0000, idx: 4'd1, cnt: 5'd4, ovf: 1'b0});
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'hC040_0000, 1'b0);
        send(32'h3F00_0000, 1'b1);
        get_result("t1", 1'b1);
        check("t1_hold_max_after", 64'(out_max),  64'h4000_0000);
        check("t1_ready_after",    64'(in_ready), 64'd1);

        // Equal maxima: earliest index wins
        sb.push_back('{mx: 32'h4000_0000, idx: 4'd0, cnt: 5'd3, ovf: 1'b0});
        send(32'h4000_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h3F80_0000, 1'b1);
        get_result("t2", 1'b1);

        // -0 followed by +0: no replacement
        sb.push_back('{mx: 32'h8000_0000, idx: 4'd0, cnt: 5'd2, ovf: 1'b0});
        send(32'h8000_0000, 1'b0);
        send(32'h0000_0000, 1'b1);
        get_result("t3", 1'b1);

        // Single element with backpressure and ignored in_valid during hold
        out_ready = 1'b0;
        sb.push_back('{mx: 32'hC040_0000, idx: 4'd0, cnt: 5'd1, ovf: 1'b0});
        send(32'hC040_0000, 1'b1);
        @(negedge clk);
        check("t4_valid_rise", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'h7F00_0000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_valid", 64'(out_valid), 64'd1);
            check("t4_stall_ready", 64'(in_ready),  64'd0);
            check("t4_stall_max",   64'(out_max),   64'hC040_0000);
            check("t4_stall_count", 64'(out_count), 64'd1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        get_result("t4", 1'b0);

        // Exactly full burst: 16 elements, no overflow
        sb.push_back('{mx: 32'h4040_0000, idx: 4'd15, cnt: 5'd16, ovf: 1'b0});
        for (int i = 0; i < 16; i++)
            send((i == 15) ? 32'h4040_0000 : ((i == 3) ? 32'h4000_0000 : 32'h3F80_0000),
                 (i == 15));
        get_result("t5", 1'b1);

        // 18-element burst: overflow, saturated count and index
        sb.push_back('{mx: 32'h4200_0000, idx: 4'd15, cnt: 5'd16, ovf: 1'b1});
        for (int i = 0; i < 18; i++)
            send((i == 17) ? 32'h4200_0000 : ((i == 5) ? 32'h4100_0000 : 32'h3F80_0000),
                 (i == 17));
        get_result("t6", 1'b1);

        // Reset in the middle of a burst
        send(32'h4100_0000, 1'b0);
        send(32'h4200_0000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t7_ready",  64'(in_ready),  64'd1);
        check("t7_valid",  64'(out_valid), 64'd0);
        check("t7_count",  64'(out_count), 64'd0);
        sb.push_back('{mx: 32'h3F00_0000, idx: 4'd0, cnt: 5'd1, ovf: 1'b0});
        send(32'h3F00_0000, 1'b1);
        get_result("t7", 1'b1);

`ifdef FP_ARGMAX_NAN_FILTER_EN
        // Leading NaN is skipped; first number seeds at its own index
        sb.push_back('{mx: 32'h3F80_0000, idx: 4'd1, cnt: 5'd2, ovf: 1'b0});
        send(32'h7FC0_0001, 1'b0);
        send(32'h3F80_0000, 1'b1);
        get_result("t8", 1'b1);
        sb.push_back('{mx: 32'h7FC0_0000, idx: 4'd0, cnt: 5'd2, ovf: 1'b0});
        send(32'h7FC0_0001, 1'b0);
        send(32'hFF80_0001, 1'b1);
        get_result("t9", 1'b1);
`else
        // NaN seeds the burst and the comparator never reports it as smaller
        sb.push_back('{mx: 32'h7FC0_0001, idx: 4'd0, cnt: 5'd2, ovf: 1'b0});
        send(32'h7FC0_0001, 1'b0);
        send(32'h3F80_0000, 1'b1);
        get_result("t8", 1'b1);
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
